// File: rtl/btb_ctrl.sv
// Branch target buffer with misprediction redirect control.
// Direct-mapped table: lookup is combinational and resolution updates the table.
// A mispredict produces a one-cycle flush/redirect pulse.
// FLUSH_LEN cycles of wrong-path suppression then follow.
// Branch and mispredict counters saturate.
module btb_ctrl #(
  parameter int ENTRIES   = 8,
  parameter int FLUSH_LEN = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] if_pc_i,
  input  logic        if_valid_i,
  output logic        pred_taken_o,
  output logic [31:0] pred_target_o,
  input  logic        ex_valid_i,
  input  logic [31:0] ex_pc_i,
  input  logic        ex_is_branch_i,
  input  logic        ex_taken_i,
  input  logic [31:0] ex_target_i,
  input  logic        ex_pred_taken_i,
  input  logic [31:0] ex_pred_target_i,
  output logic        flush_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  input  logic        clr_stats_i,
  output logic [15:0] br_count_o,
  output logic [15:0] mispred_count_o
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;
  localparam int CNT_W = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;

  typedef enum logic {IDLE, FLUSH} state_e;

  // Table storage: valid/counter are reset, tag/target are don't-care while invalid
  logic             valid_q  [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];

  state_e           state_q;
  logic [CNT_W-1:0] flush_cnt_q;
  logic             flush_q;
  logic             redirect_valid_q;
  logic [31:0]      redirect_pc_q;
  logic [15:0]      br_count_q;
  logic [15:0]      mispred_count_q;

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  logic             if_hit, ex_hit;
  logic             accept, mispredict;
  logic [1:0]       ex_ctr_d;

  assign if_idx = if_pc_i[2 +: IDX_W];
  assign if_tag = if_pc_i[31 -: TAG_W];
  assign ex_idx = ex_pc_i[2 +: IDX_W];
  assign ex_tag = ex_pc_i[31 -: TAG_W];

  // Lookup sees pre-update table contents; there is no bypass from EX
  assign if_hit        = if_valid_i & valid_q[if_idx] & (tag_q[if_idx] == if_tag);
  assign pred_taken_o  = if_hit & ctr_q[if_idx][1];
  assign pred_target_o = pred_taken_o ? target_q[if_idx] : if_pc_i + 32'd4;

  // Resolutions arriving while flushing belong to wrong-path work and are dropped
  assign ex_hit     = valid_q[ex_idx] & (tag_q[ex_idx] == ex_tag);
  assign accept     = ex_valid_i & ex_is_branch_i & (state_q == IDLE);
  assign mispredict = accept & ((ex_taken_i != ex_pred_taken_i) |
                      (ex_taken_i & ex_pred_taken_i & (ex_target_i != ex_pred_target_i)));

  // Saturating 2-bit counter step for the resolving entry
  always_comb begin
    ex_ctr_d = ctr_q[ex_idx];
    if (ex_taken_i && ctr_q[ex_idx] != 2'b11)
      ex_ctr_d = ctr_q[ex_idx] + 2'b01;
    else if (!ex_taken_i && ctr_q[ex_idx] != 2'b00)
      ex_ctr_d = ctr_q[ex_idx] - 2'b01;
  end

  // Redirect FSM: one-cycle flush/redirect pulse, then hold FLUSH for FLUSH_LEN cycles
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q          <= IDLE;
      flush_cnt_q      <= '0;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'd0;
    end else begin
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mispredict) begin
            state_q          <= FLUSH;
            flush_cnt_q      <= CNT_W'(FLUSH_LEN - 1);
            flush_q          <= 1'b1;
            redirect_valid_q <= 1'b1;
            redirect_pc_q    <= ex_taken_i ? ex_target_i : ex_pc_i + 32'd4;
          end
        end
        FLUSH: begin
          if (flush_cnt_q == '0)
            state_q <= IDLE;
          else
            flush_cnt_q <= flush_cnt_q - 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Valid bits and counters: train on hit, allocate weakly-taken on taken miss
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b00;
      end
    end else if (accept) begin
      if (ex_hit) begin
        ctr_q[ex_idx] <= ex_ctr_d;
      end else if (ex_taken_i) begin
        valid_q[ex_idx] <= 1'b1;
        ctr_q[ex_idx]   <= 2'b10;
      end
    end
  end

  // Tag/target payload: any taken resolution writes the target, misses also write the tag
  always_ff @(posedge clk_i) begin
    if (accept && ex_taken_i) begin
      target_q[ex_idx] <= ex_target_i;
      if (!ex_hit)
        tag_q[ex_idx] <= ex_tag;
    end
  end

  // Statistics: clear wins over a same-cycle increment, both counters saturate
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      br_count_q      <= 16'd0;
      mispred_count_q <= 16'd0;
    end else if (clr_stats_i) begin
      br_count_q      <= 16'd0;
      mispred_count_q <= 16'd0;
    end else begin
      if (accept && br_count_q != 16'hFFFF)
        br_count_q <= br_count_q + 16'd1;
      if (mispredict && mispred_count_q != 16'hFFFF)
        mispred_count_q <= mispred_count_q + 16'd1;
    end
  end

  assign flush_o          = flush_q;
  assign redirect_valid_o = redirect_valid_q;
  assign redirect_pc_o    = redirect_pc_q;
  assign br_count_o       = br_count_q;
  assign mispred_count_o  = mispred_count_q;

endmodule

// File: doc/btb_ctrl.md
BTB_CTRL -- requirements
Module: btb_ctrl

Interface
REQ-001 SHALL provide parameter ENTRIES, default 8, meaning number of direct-mapped BTB entries, indexed by PC[4:2].
REQ-002 SHALL provide parameter FLUSH_LEN, default 2, meaning cycles of wrong-path suppression after a redirect.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 CLK  in  1  rising-edge clock.
REQ-005 RST_N  in  1  asynchronous active-low reset.
REQ-006 IF_PC  in  32  fetch-stage PC for lookup.
REQ-007 IF_Valid  in  1  fetch slot holds a real instruction.
REQ-008 Pred_Taken  out  1  BTB predicts taken.
REQ-009 Pred_Target  out  32  predicted next PC.
REQ-010 EX_Valid  in  1  EX-stage resolution is present this cycle.
REQ-011 EX_PC  in  32  PC of resolving instruction.
REQ-012 EX_IsBranch  in  1  resolving instruction is a branch or jump (BranchSig).
REQ-013 EX_Taken  in  1  actual outcome (Branched).
REQ-014 EX_Target  in  32  actual taken target (PC_Next when taken).
REQ-015 EX_PredTaken  in  1  prediction carried down the pipe for this instruction.
REQ-016 EX_PredTarget  in  32  predicted target carried down the pipe.
REQ-017 Flush  out  1  kill IF/ID and ID/EX contents.
REQ-018 Redirect_Valid  out  1  load Redirect_PC into the PC register.
REQ-019 Redirect_PC  out  32  corrected next PC.
REQ-020 Clr_Stats  in  1  synchronous clear of statistics counters.
REQ-021 Br_Count  out  16  resolved branches counted.
REQ-022 Mispred_Count  out  16  mispredictions counted.

Function
REQ-023 Each entry SHALL hold valid bit, tag PC[31:5], 32-bit target, and 2-bit saturating counter.
REQ-024 Lookup SHALL be combinational from current table state: hit = IF_Valid & valid & tag match; Pred_Taken = hit & ctr[1]; Pred_Target = Pred_Taken ? entry target : IF_PC+4 (mod 2^32).
REQ-025 FSM states SHALL be IDLE and FLUSH; resolutions are accepted only in IDLE.
REQ-026 Accepted resolution = EX_Valid & EX_IsBranch & state==IDLE; all other EX inputs SHALL be ignored.
REQ-027 Mispredict = accepted & (EX_Taken != EX_PredTaken | (EX_Taken & EX_PredTaken & EX_Target != EX_PredTarget)).
REQ-028 On mispredict in cycle t, Flush and Redirect_Valid SHALL be high for exactly cycle t+1, Redirect_PC = EX_Taken ? EX_Target : EX_PC+4, and the FSM SHALL enter FLUSH.
REQ-029 FLUSH SHALL last FLUSH_LEN cycles (counting from t+1), then return to IDLE; no second redirect can be issued in FLUSH.
REQ-030 Table update on accepted resolution, at the clock edge ending cycle t: hit -> ctr +1 if taken else -1, saturating at 3 and 0; target overwritten if taken.
REQ-031 Miss and taken -> allocate: valid=1, tag, target=EX_Target, ctr=2'b10; miss and not taken -> no change.
REQ-032 Lookup and update to the same index in the same cycle SHALL return pre-update contents (no bypass).
REQ-033 Br_Count SHALL increment per accepted resolution; Mispred_Count per mispredict; both saturate at 0xFFFF.
REQ-034 Clr_Stats SHALL zero both counters next edge and take priority over a same-cycle increment.
REQ-035 Redirect_PC SHALL hold its last value when Redirect_Valid is low.

Reset
REQ-036 RST_N low SHALL immediately clear all valid bits and counters, set state IDLE, and drive Flush=0, Redirect_Valid=0, Redirect_PC=0, Br_Count=0, Mispred_Count=0, including mid-FLUSH.
REQ-037 Targets and tags need no reset; with valid=0, Pred_Taken=0 after reset.

Verification
REQ-038 Cold miss: after reset, IF_PC=0x00400010 -> Pred_Taken=0, Pred_Target=0x00400014.
REQ-039 Allocate: resolve EX_PC=0x00400010 taken, target 0x00400040, PredTaken=0 -> Flush/Redirect_Valid one cycle, Redirect_PC=0x00400040; next lookup of 0x00400010 -> Pred_Taken=1, Pred_Target=0x00400040.
REQ-040 Saturation: three taken resolutions then two not-taken on the same entry -> ctr 3,3,3 then 2,1; the lookup after the second not-taken gives Pred_Taken=0.
REQ-041 Suppression: mispredict at t, another mispredicting EX_Valid at t+1 and t+2 -> single Flush pulse, Br_Count +1 only, table unchanged by t+1/t+2.
REQ-042 Wrong target: EX_Taken=1, PredTaken=1, EX_Target=0x00400080, PredTarget=0x00400040 -> redirect to 0x00400080, Mispred_Count +1.
REQ-043 Reset mid-FLUSH and Clr_Stats colliding with an increment -> state IDLE, counters 0.
